// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : icache_pkg
// Purpose  : Shared types and helpers for the set-associative instruction
//            cache: refill FSM state encoding, a constant-safe clog2,
//            the kseg1 uncached-window test and address-split width helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RREQ  = 2'd1,
    RWAIT = 2'd2,
    FILL  = 2'd3
  } state_t;

  localparam int          WORD_BYTES       = 4;
  localparam logic [1:0]  BRIDGE_SIZE_WORD = 2'b10;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // kseg1 window 0xA000_0000 - 0xBFFF_FFFF is never cached.
  function automatic logic is_uncached(input logic [31:0] addr);
    return addr[31:29] == 3'b101;
  endfunction

  // Byte-offset bits of a line (word select plus the two byte bits).
  function automatic int offset_width(input int line_words);
    return clog2(line_words) + 2;
  endfunction

  function automatic int tag_width(input int index_width, input int line_words);
    return 32 - index_width - offset_width(line_words);
  endfunction

endpackage : icache_pkg
`default_nettype wire

// File: rtl/icache_way.sv
`default_nettype none
// ============================================================================
// Module   : icache_way
// Purpose  : Storage for one way of the instruction cache: a tag array and a
//            per-word data array, both written synchronously and read
//            combinationally so a hit can be answered in the request cycle.
//            Arrays carry no reset; validity is tracked by the parent.
// Ports    : clk                      clock
//            rd_index/rd_word         combinational read address
//            rd_tag/rd_data           tag and selected word of that set
//            tag_we/wr_tag            tag write for set wr_index
//            data_we/wr_word/wr_data  single-word write for set wr_index
// Revision : 1.0 - initial release
// ============================================================================
module icache_way #(
  parameter int INDEX_WIDTH = 7,
  parameter int TAG_WIDTH   = 21,
  parameter int LINE_WORDS  = 4,
  parameter int WW          = 2
) (
  input  logic                   clk,
  input  logic [INDEX_WIDTH-1:0] rd_index,
  input  logic [WW-1:0]          rd_word,
  output logic [TAG_WIDTH-1:0]   rd_tag,
  output logic [31:0]            rd_data,
  input  logic                   tag_we,
  input  logic                   data_we,
  input  logic [INDEX_WIDTH-1:0] wr_index,
  input  logic [WW-1:0]          wr_word,
  input  logic [TAG_WIDTH-1:0]   wr_tag,
  input  logic [31:0]            wr_data
);

  localparam int SETS = 1 << INDEX_WIDTH;

  logic [TAG_WIDTH-1:0] tag_mem  [SETS];
  logic [31:0]          data_mem [SETS][LINE_WORDS];

  always_ff @(posedge clk) begin
    if (tag_we)  tag_mem[wr_index]           <= wr_tag;
    if (data_we) data_mem[wr_index][wr_word] <= wr_data;
  end

  assign rd_tag  = tag_mem[rd_index];
  assign rd_data = data_mem[rd_index][rd_word];

endmodule : icache_way
`default_nettype wire

// File: rtl/inst_cache_sa.sv
`default_nettype none
// ============================================================================
// Module   : inst_cache_sa
// Purpose  : Set-associative instruction cache with multi-word lines,
//            critical-word-first refill over a single-word sram-like bridge,
//            per-set round-robin replacement, single-cycle invalidate-all and
//            a kseg1 uncached bypass. Hits complete in the request cycle.
// Ports    : clk, resetn (async, active low), inv_all (flush, level)
//            cpu_inst_*   sram-like slave port toward the core (read only)
//            cache_inst_* sram-like master port toward the AXI bridge
// Revision : 1.0 - initial release
// ============================================================================
module inst_cache_sa
  import icache_pkg::*;
#(
  parameter int WAYS        = 2,
  parameter int INDEX_WIDTH = 7,
  parameter int LINE_WORDS  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inv_all,
  input  logic        cpu_inst_req,
  input  logic        cpu_inst_wr,
  input  logic [1:0]  cpu_inst_size,
  input  logic [31:0] cpu_inst_addr,
  input  logic [31:0] cpu_inst_wdata,
  output logic [31:0] cpu_inst_rdata,
  output logic        cpu_inst_addr_ok,
  output logic        cpu_inst_data_ok,
  output logic        cache_inst_req,
  output logic        cache_inst_wr,
  output logic [1:0]  cache_inst_size,
  output logic [31:0] cache_inst_addr,
  output logic [31:0] cache_inst_wdata,
  input  logic [31:0] cache_inst_rdata,
  input  logic        cache_inst_addr_ok,
  input  logic        cache_inst_data_ok
);

  localparam int SETS         = 1 << INDEX_WIDTH;
  localparam int OFFSET_WIDTH = offset_width(LINE_WORDS);
  localparam int TAG_WIDTH    = tag_width(INDEX_WIDTH, LINE_WORDS);
  // Counter widths are kept at least 1 bit; masks force them to 0 when the
  // corresponding parameter is 1.
  localparam int WW = (LINE_WORDS > 1) ? clog2(LINE_WORDS) : 1;
  localparam int WB = (WAYS > 1) ? clog2(WAYS) : 1;
  localparam logic [WW-1:0] WORD_MASK = WW'(LINE_WORDS - 1);
  localparam logic [WB-1:0] WAY_MASK  = WB'(WAYS - 1);
  localparam logic [31:0]   OFF_MASK  = 32'((1 << OFFSET_WIDTH) - 1);

  // The core port is read-only and word-sized.
  logic unused_cpu_inputs;
  assign unused_cpu_inputs = ^{cpu_inst_wr, cpu_inst_size, cpu_inst_wdata};

  assign cache_inst_wr    = 1'b0;
  assign cache_inst_size  = BRIDGE_SIZE_WORD;
  assign cache_inst_wdata = 32'd0;

  state_t state, state_nx;

  logic [SETS-1:0]        valid [WAYS];
  logic [WB-1:0]          rr    [SETS];
  logic [31:0]            lat_addr;
  logic [WW-1:0]          crit;
  logic [WW-1:0]          k;
  logic                   uc;
  logic [WB-1:0]          victim;
  logic                   pend_flush;

  // FSM strobes consumed by the datapath registers.
  logic do_flush, start_miss, start_uc, word_we, fill, k_inc;

  // Request-side address split used for the lookup.
  logic [TAG_WIDTH-1:0]   req_tag;
  logic [INDEX_WIDTH-1:0] req_index;
  logic [WW-1:0]          req_word;
  assign req_tag   = cpu_inst_addr[31 -: TAG_WIDTH];
  assign req_index = cpu_inst_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_word  = WW'((cpu_inst_addr >> 2) & 32'(LINE_WORDS - 1));

  // Latched-miss address split used during refill.
  logic [TAG_WIDTH-1:0]   lat_tag;
  logic [INDEX_WIDTH-1:0] lat_index;
  logic [WW-1:0]          cur_word;
  logic [31:0]            line_base;
  assign lat_tag   = lat_addr[31 -: TAG_WIDTH];
  assign lat_index = lat_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign cur_word  = (crit + k) & WORD_MASK;
  assign line_base = lat_addr & ~OFF_MASK;

  logic [TAG_WIDTH-1:0] rd_tag  [WAYS];
  logic [31:0]          rd_data [WAYS];
  logic [WAYS-1:0]      hit_vec;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way #(
      .INDEX_WIDTH (INDEX_WIDTH),
      .TAG_WIDTH   (TAG_WIDTH),
      .LINE_WORDS  (LINE_WORDS),
      .WW          (WW)
    ) u_way (
      .clk      (clk),
      .rd_index (req_index),
      .rd_word  (req_word),
      .rd_tag   (rd_tag[w]),
      .rd_data  (rd_data[w]),
      .tag_we   (fill && (victim == WB'(w))),
      .data_we  (word_we && (victim == WB'(w))),
      .wr_index (lat_index),
      .wr_word  (cur_word),
      .wr_tag   (lat_tag),
      .wr_data  (cache_inst_rdata)
    );
    assign hit_vec[w] = valid[w][req_index] && (rd_tag[w] == req_tag);
  end

  // Lowest-numbered hitting way wins if more than one ever matches.
  logic        hit;
  logic [31:0] hit_word;
  always_comb begin
    hit_word = 32'd0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_word = rd_data[i];
    end
  end
  assign hit = |hit_vec;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx         = state;
    cpu_inst_addr_ok = 1'b0;
    cpu_inst_data_ok = 1'b0;
    cpu_inst_rdata   = 32'd0;
    cache_inst_req   = 1'b0;
    cache_inst_addr  = 32'd0;
    do_flush         = 1'b0;
    start_miss       = 1'b0;
    start_uc         = 1'b0;
    word_we          = 1'b0;
    fill             = 1'b0;
    k_inc            = 1'b0;
    case (state)
      IDLE: begin
        // A flush (new or deferred) takes the cycle; any request waits.
        if (inv_all || pend_flush) begin
          do_flush = 1'b1;
        end else if (cpu_inst_req) begin
          if (is_uncached(cpu_inst_addr)) begin
            start_uc = 1'b1;
            state_nx = RREQ;
          end else if (hit) begin
            cpu_inst_addr_ok = 1'b1;
            cpu_inst_data_ok = 1'b1;
            cpu_inst_rdata   = hit_word;
          end else begin
            start_miss = 1'b1;
            state_nx   = RREQ;
          end
        end
      end
      RREQ: begin
        cache_inst_req  = 1'b1;
        cache_inst_addr = uc ? lat_addr : (line_base | (32'(cur_word) << 2));
        if (cache_inst_addr_ok) begin
          state_nx = RWAIT;
          // The core's request is acknowledged with the first beat only.
          if (uc || (k == '0)) cpu_inst_addr_ok = 1'b1;
        end
      end
      RWAIT: begin
        if (cache_inst_data_ok) begin
          word_we = !uc;
          if (uc || (k == '0)) begin
            cpu_inst_data_ok = 1'b1;
            cpu_inst_rdata   = cache_inst_rdata;
          end
          if (uc) begin
            state_nx = IDLE;
          end else if (k == WORD_MASK) begin
            state_nx = FILL;
          end else begin
            k_inc    = 1'b1;
            state_nx = RREQ;
          end
        end
      end
      FILL: begin
        fill     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int w = 0; w < WAYS; w++) valid[w] <= '0;
      for (int s = 0; s < SETS; s++) rr[s] <= '0;
      lat_addr   <= 32'd0;
      crit       <= '0;
      k          <= '0;
      uc         <= 1'b0;
      victim     <= '0;
      pend_flush <= 1'b0;
    end else begin
      if (do_flush)                        pend_flush <= 1'b0;
      else if (inv_all && (state != IDLE)) pend_flush <= 1'b1;

      if (do_flush) begin
        for (int w = 0; w < WAYS; w++) valid[w] <= '0;
      end

      if (start_miss) begin
        lat_addr <= cpu_inst_addr;
        crit     <= req_word;
        k        <= '0;
        uc       <= 1'b0;
        victim   <= rr[req_index];
        // The victim line goes invalid now so a partially refilled line can
        // never be hit if the refill is abandoned.
        valid[rr[req_index]][req_index] <= 1'b0;
      end

      if (start_uc) begin
        lat_addr <= cpu_inst_addr;
        k        <= '0;
        uc       <= 1'b1;
      end

      if (k_inc) k <= (k + WW'(1)) & WORD_MASK;

      if (fill) begin
        valid[victim][lat_index] <= 1'b1;
        rr[lat_index]            <= (rr[lat_index] + WB'(1)) & WAY_MASK;
      end
    end
  end

endmodule : inst_cache_sa
`default_nettype wire

// File: tb/tb_inst_cache_sa.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_cache_sa
// Purpose  : Self-checking bench for inst_cache_sa (WAYS=2, LINE_WORDS=4):
//            bridge responder with immediate addr_ok and data_ok one cycle
//            later, a scoreboard of expected read data, a vector table of
//            reads with expected latencies and bridge traffic, and
//            hand-written flush / reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_cache_sa;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inv_all = 1'b0;
  logic        cpu_req = 1'b0;
  logic [31:0] cpu_addr = 32'd0;
  logic [31:0] cpu_inst_rdata;
  logic        cpu_inst_addr_ok, cpu_inst_data_ok;
  logic        cache_inst_req, cache_inst_wr;
  logic [1:0]  cache_inst_size;
  logic [31:0] cache_inst_addr, cache_inst_wdata;
  logic [31:0] br_rdata = 32'd0;
  logic        br_dok = 1'b0;
  logic        br_aok;

  int tests = 0;
  int failed = 0;

  logic [31:0] exp_q[$];
  logic [31:0] br_q[$];

  always #5 clk = ~clk;

  inst_cache_sa #(.WAYS(2), .INDEX_WIDTH(7), .LINE_WORDS(4)) dut (
    .clk                (clk),
    .resetn             (resetn),
    .inv_all            (inv_all),
    .cpu_inst_req       (cpu_req),
    .cpu_inst_wr        (1'b0),
    .cpu_inst_size      (2'b10),
    .cpu_inst_addr      (cpu_addr),
    .cpu_inst_wdata     (32'd0),
    .cpu_inst_rdata     (cpu_inst_rdata),
    .cpu_inst_addr_ok   (cpu_inst_addr_ok),
    .cpu_inst_data_ok   (cpu_inst_data_ok),
    .cache_inst_req     (cache_inst_req),
    .cache_inst_wr      (cache_inst_wr),
    .cache_inst_size    (cache_inst_size),
    .cache_inst_addr    (cache_inst_addr),
    .cache_inst_wdata   (cache_inst_wdata),
    .cache_inst_rdata   (br_rdata),
    .cache_inst_addr_ok (br_aok),
    .cache_inst_data_ok (br_dok)
  );

  // Backing memory contents: a bijection of the address so every word differs.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h3C5A_0F96;
  endfunction

  // Bridge: accepts immediately, returns data the following cycle.
  assign br_aok = cache_inst_req;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      br_dok <= 1'b0;
    end else begin
      br_dok   <= cache_inst_req && br_aok;
      br_rdata <= mem_word(cache_inst_addr);
      if (cache_inst_req && br_aok) br_q.push_back(cache_inst_addr);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every returned word is compared with the oldest expectation.
  always @(negedge clk) begin
    if (resetn && cpu_inst_data_ok) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_data_ok: got %h expected no return", cpu_inst_rdata);
      end else begin
        check("rdata", cpu_inst_rdata, exp_q.pop_front());
      end
    end
  end

  // Issue one read; reports cycles from request to addr_ok and to data_ok.
  task automatic cpu_read(input logic [31:0] a, output int alat, output int dlat);
    int cyc;
    bit ga, gd;
    cyc = 0; ga = 0; gd = 0; alat = -1; dlat = -1;
    exp_q.push_back(mem_word(a));
    @(posedge clk); #1;
    cpu_req = 1'b1;
    cpu_addr = a;
    while (!(ga && gd) && cyc < 200) begin
      @(negedge clk);
      if (!ga && cpu_inst_addr_ok) begin ga = 1; alat = cyc; end
      if (!gd && cpu_inst_data_ok) begin gd = 1; dlat = cyc; end
      @(posedge clk); #1;
      if (ga) cpu_req = 1'b0;
      cyc++;
    end
    cpu_req = 1'b0;
    if (!(ga && gd)) begin
      tests++;
      failed++;
      $display("FAIL read_timeout: addr %h got no handshake, expected addr_ok and data_ok", a);
    end
  endtask

  task automatic settle();
    repeat (12) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] addr;
    int          alat;
    int          dlat;
    int          nbr;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int alat, dlat;
    logic [31:0] ea;

    vecs[0]  = '{32'h0000_1008, 1, 2, 4};  // cold miss, critical word 2
    vecs[1]  = '{32'h0000_1000, 0, 0, 0};
    vecs[2]  = '{32'h0000_1004, 0, 0, 0};
    vecs[3]  = '{32'h0000_100C, 0, 0, 0};
    vecs[4]  = '{32'h0001_1000, 1, 2, 4};  // same set, goes to way 1
    vecs[5]  = '{32'h0002_1000, 1, 2, 4};  // evicts 0x1000 (way 0)
    vecs[6]  = '{32'h0001_1000, 0, 0, 0};
    vecs[7]  = '{32'h0000_1000, 1, 2, 4};  // evicts 0x11000 (way 1)
    vecs[8]  = '{32'h0002_1000, 0, 0, 0};
    vecs[9]  = '{32'h0001_1000, 1, 2, 4};
    vecs[10] = '{32'h0000_300C, 1, 2, 4};  // critical word last: wraps
    vecs[11] = '{32'h0000_3004, 0, 0, 0};
    vecs[12] = '{32'hBFC0_0000, 1, 2, 1};  // uncached, never allocated
    vecs[13] = '{32'hBFC0_0000, 1, 2, 1};

    // Reset state, with a request pending during reset.
    cpu_req = 1'b1;
    cpu_addr = 32'h0000_1000;
    #12;
    check("rst_addr_ok", 32'(cpu_inst_addr_ok), 32'd0);
    check("rst_data_ok", 32'(cpu_inst_data_ok), 32'd0);
    check("rst_rdata", cpu_inst_rdata, 32'd0);
    check("rst_cache_req", 32'(cache_inst_req), 32'd0);
    check("rst_cache_addr", cache_inst_addr, 32'd0);
    check("const_wr", 32'(cache_inst_wr), 32'd0);
    check("const_size", 32'(cache_inst_size), 32'd2);
    check("const_wdata", cache_inst_wdata, 32'd0);
    cpu_req = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(posedge clk);

    for (int v = 0; v < 14; v++) begin
      br_q.delete();
      cpu_read(vecs[v].addr, alat, dlat);
      settle();
      check($sformatf("v%0d_alat", v), 32'(alat), 32'(vecs[v].alat));
      check($sformatf("v%0d_dlat", v), 32'(dlat), 32'(vecs[v].dlat));
      check($sformatf("v%0d_nbr", v), 32'(br_q.size()), 32'(vecs[v].nbr));
      for (int i = 0; i < vecs[v].nbr && i < br_q.size(); i++) begin
        if (vecs[v].addr[31:29] == 3'b101)
          ea = vecs[v].addr;
        else
          ea = {vecs[v].addr[31:4], 2'(vecs[v].addr[3:2] + 2'(i)), 2'b00};
        check($sformatf("v%0d_braddr%0d", v, i), br_q[i], ea);
      end
    end

    // Flush after a hit makes the line miss again.
    cpu_read(32'h0000_4000, alat, dlat);
    settle();
    cpu_read(32'h0000_4000, alat, dlat);
    check("flush_prehit_alat", 32'(alat), 32'd0);
    @(posedge clk); #1;
    inv_all = 1'b1;
    @(posedge clk); #1;
    inv_all = 1'b0;
    cpu_read(32'h0000_4000, alat, dlat);
    settle();
    check("flush_miss_alat", 32'(alat), 32'd1);

    // Flush and request together: flush wins, request then misses.
    br_q.delete();
    exp_q.push_back(mem_word(32'h0000_4000));
    @(posedge clk); #1;
    inv_all = 1'b1;
    cpu_req = 1'b1;
    cpu_addr = 32'h0000_4000;
    @(negedge clk);
    check("simul_addr_ok", 32'(cpu_inst_addr_ok), 32'd0);
    check("simul_data_ok", 32'(cpu_inst_data_ok), 32'd0);
    @(posedge clk); #1;
    inv_all = 1'b0;
    @(negedge clk);
    check("simul_idle_addr_ok", 32'(cpu_inst_addr_ok), 32'd0);
    @(negedge clk);
    check("simul_rreq_addr_ok", 32'(cpu_inst_addr_ok), 32'd1);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    settle();
    check("simul_nbr", 32'(br_q.size()), 32'd4);

    // Flush during refill: line completes, then is dropped on return to IDLE.
    br_q.delete();
    cpu_read(32'h0000_5000, alat, dlat);
    @(posedge clk); #1;
    inv_all = 1'b1;
    @(posedge clk); #1;
    inv_all = 1'b0;
    settle();
    check("rwflush_nbr", 32'(br_q.size()), 32'd4);
    cpu_read(32'h0000_5000, alat, dlat);
    settle();
    check("rwflush_miss_alat", 32'(alat), 32'd1);

    // Reset in RWAIT at k=2 abandons the line.
    cpu_read(32'h0000_6008, alat, dlat);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check("midrst_cache_req", 32'(cache_inst_req), 32'd0);
    check("midrst_cache_addr", cache_inst_addr, 32'd0);
    check("midrst_addr_ok", 32'(cpu_inst_addr_ok), 32'd0);
    check("midrst_data_ok", 32'(cpu_inst_data_ok), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    br_q.delete();
    cpu_read(32'h0000_6008, alat, dlat);
    settle();
    check("midrst_alat", 32'(alat), 32'd1);
    check("midrst_dlat", 32'(dlat), 32'd2);
    check("midrst_nbr", 32'(br_q.size()), 32'd4);
    cpu_read(32'h0000_6000, alat, dlat);
    check("midrst_hit_alat", 32'(alat), 32'd0);
    settle();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_inst_cache_sa
`default_nettype wire
